// File: rtl/cva6_irq_sequencer.sv
// rtl/cva6_irq_sequencer.sv - synchronise, edge-detect and latch CVA6 interrupt lines
// Pending ext/ipi/timer bits are cleared through a two-cycle valid/ready clear FSM.
module cva6_irq_sequencer #(
  parameter int unsigned NR_CORES    = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DBG_HOLD    = 16,
  localparam int unsigned CW = (NR_CORES > 1) ? $clog2(NR_CORES) : 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [2*NR_CORES-1:0] irqs_in,
  input  logic [NR_CORES-1:0]   ipi_in,
  input  logic [NR_CORES-1:0]   timer_irq_i,
  input  logic [NR_CORES-1:0]   debug_req_irq,
  input  logic                  clr_valid_i,
  output logic                  clr_ready_o,
  input  logic [1:0]            clr_src_i,
  input  logic [CW-1:0]         clr_core_i,
  output logic                  clr_done_o,
  output logic                  clr_err_o,
  output logic [2*NR_CORES-1:0] irq_o,
  output logic [NR_CORES-1:0]   ipi_o,
  output logic [NR_CORES-1:0]   timer_irq_o,
  output logic [NR_CORES-1:0]   debug_req_o,
  output logic                  lost_o
);

  localparam int unsigned NP = 4 * NR_CORES;
  localparam int unsigned NI = 5 * NR_CORES;
  localparam logic [7:0] DBG_V = 8'(DBG_HOLD);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_e;

  logic [NI-1:0]            raw;
  logic [NI-1:0]            sync_q [SYNC_STAGES];
  logic [NI-1:0]            sync_d [SYNC_STAGES];
  logic [NI-1:0]            hist_q, hist_d;
  logic [NI-1:0]            edge_q, edge_d;
  logic [SYNC_STAGES:0]     prime_q, prime_d;
  logic [NP-1:0]            pend_q, pend_d;
  logic [NP-1:0]            clr_mask;
  logic [NR_CORES-1:0][7:0] cnt_q, cnt_d;
  state_e                   state_q, state_d;
  logic [1:0]               src_q, src_d;
  logic [CW-1:0]            core_q, core_d;
  logic                     ready_en_q;
  logic                     lost_q, lost_d;
  logic                     in_range;
  int                       tgt;

  // Bit layout: ext [2N-1:0], ipi [3N-1:2N], timer [4N-1:3N], debug [5N-1:4N]
  assign raw = {debug_req_irq, timer_irq_i, ipi_in, irqs_in};

  // Edges are masked until the history flop holds a real sample, so lines
  // that are already high when reset releases do not fire.
  always_comb begin
    sync_d[0] = raw;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    hist_d  = sync_q[SYNC_STAGES-1];
    prime_d = {prime_q[SYNC_STAGES-1:0], 1'b1};
    edge_d  = prime_q[SYNC_STAGES] ? (sync_q[SYNC_STAGES-1] & ~hist_q) : '0;
  end

  always_comb begin
    in_range = int'(core_q) < int'(NR_CORES);
    case (src_q)
      2'd0:    tgt = 2 * int'(core_q);
      2'd1:    tgt = 2 * int'(core_q) + 1;
      2'd2:    tgt = 2 * int'(NR_CORES) + int'(core_q);
      default: tgt = 3 * int'(NR_CORES) + int'(core_q);
    endcase
    clr_mask = '0;
    for (int i = 0; i < int'(NP); i++) begin
      clr_mask[i] = (state_q == S_CLEAR) && in_range && (i == tgt);
    end
    // A set in the clear cycle wins and is not counted as a lost edge.
    pend_d = edge_q[NP-1:0] | (pend_q & ~clr_mask);
    lost_d = lost_q | (|(edge_q[NP-1:0] & pend_q & ~clr_mask));
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int c = 0; c < int'(NR_CORES); c++) begin
      if (edge_q[NP+c]) begin
        cnt_d[c] = DBG_V;
      end else if (cnt_q[c] != 8'd0) begin
        cnt_d[c] = cnt_q[c] - 8'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    core_d  = core_q;
    case (state_q)
      S_IDLE: begin
        if (clr_valid_i && clr_ready_o) begin
          src_d   = clr_src_i;
          core_d  = clr_core_i;
          state_d = S_CLEAR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      hist_q     <= '0;
      edge_q     <= '0;
      prime_q    <= '0;
      pend_q     <= '0;
      cnt_q      <= '0;
      state_q    <= S_IDLE;
      src_q      <= '0;
      core_q     <= '0;
      ready_en_q <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      hist_q     <= hist_d;
      edge_q     <= edge_d;
      prime_q    <= prime_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      src_q      <= src_d;
      core_q     <= core_d;
      ready_en_q <= 1'b1;
      lost_q     <= lost_d;
    end
  end

  always_comb begin
    for (int c = 0; c < int'(NR_CORES); c++) begin
      debug_req_o[c] = (cnt_q[c] != 8'd0);
    end
  end

  assign clr_ready_o = ready_en_q && (state_q == S_IDLE);
  assign clr_done_o  = (state_q == S_CLEAR);
  assign clr_err_o   = (state_q == S_CLEAR) && !in_range;
  assign irq_o       = pend_q[2*NR_CORES-1:0];
  assign ipi_o       = pend_q[3*NR_CORES-1:2*NR_CORES];
  assign timer_irq_o = pend_q[4*NR_CORES-1:3*NR_CORES];
  assign lost_o      = lost_q;

endmodule

// File: tb/tb_cva6_irq_sequencer.sv
// tb/tb_cva6_irq_sequencer.sv - directed table-driven bench for cva6_irq_sequencer
module tb_cva6_irq_sequencer;

  localparam int N = 3;

  logic         aclk;
  logic         aresetn;
  logic [2*N-1:0] irqs_in;
  logic [N-1:0] ipi_in, timer_irq_i, debug_req_irq;
  logic         clr_valid_i, clr_ready_o;
  logic [1:0]   clr_src_i;
  logic [1:0]   clr_core_i;
  logic         clr_done_o, clr_err_o;
  logic [2*N-1:0] irq_o;
  logic [N-1:0] ipi_o, timer_irq_o, debug_req_o;
  logic         lost_o;

  cva6_irq_sequencer #(.NR_CORES(N), .SYNC_STAGES(2), .DBG_HOLD(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .irqs_in(irqs_in), .ipi_in(ipi_in),
    .timer_irq_i(timer_irq_i), .debug_req_irq(debug_req_irq),
    .clr_valid_i(clr_valid_i), .clr_ready_o(clr_ready_o), .clr_src_i(clr_src_i),
    .clr_core_i(clr_core_i), .clr_done_o(clr_done_o), .clr_err_o(clr_err_o),
    .irq_o(irq_o), .ipi_o(ipi_o), .timer_irq_o(timer_irq_o),
    .debug_req_o(debug_req_o), .lost_o(lost_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [5:0] irqs;
    logic [2:0] ipi;
    logic [2:0] tmr;
    logic [5:0] e_irq;
    logic [2:0] e_ipi;
    logic [2:0] e_tmr;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_outs(input string name, input logic [5:0] ei, input logic [2:0] ep,
                          input logic [2:0] et, input logic el);
    chk({name, ".irq"}, 32'(irq_o), 32'(ei));
    chk({name, ".ipi"}, 32'(ipi_o), 32'(ep));
    chk({name, ".tmr"}, 32'(timer_irq_o), 32'(et));
    chk({name, ".lost"}, 32'(lost_o), 32'(el));
  endtask

  task automatic do_clear(input string name, input logic [1:0] s, input logic [1:0] c,
                          input logic eerr);
    clr_src_i   = s;
    clr_core_i  = c;
    clr_valid_i = 1'b1;
    chk({name, ".ready_idle"}, 32'(clr_ready_o), 32'd1);
    tick();
    chk({name, ".done"}, 32'(clr_done_o), 32'd1);
    chk({name, ".err"}, 32'(clr_err_o), 32'(eerr));
    chk({name, ".ready_busy"}, 32'(clr_ready_o), 32'd0);
    clr_valid_i = 1'b0;
    clr_src_i   = ~s;
    clr_core_i  = ~c;
    tick();
    chk({name, ".done_end"}, 32'(clr_done_o), 32'd0);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    #1;
    tick();
    aresetn = 1'b1;
    repeat (5) tick();
  endtask

  initial begin
    int cnt, first, last;
    logic [7:0] done_seq;

    vecs[0] = '{6'b000001, 3'b000, 3'b000, 6'b000001, 3'b000, 3'b000};
    vecs[1] = '{6'b100100, 3'b010, 3'b000, 6'b100101, 3'b010, 3'b000};
    vecs[2] = '{6'b000000, 3'b001, 3'b101, 6'b100101, 3'b011, 3'b101};
    vecs[3] = '{6'b010010, 3'b000, 3'b000, 6'b110111, 3'b011, 3'b101};
    vecs[4] = '{6'b000000, 3'b000, 3'b000, 6'b110111, 3'b011, 3'b101};

    aresetn = 1'b0;
    irqs_in = '1; ipi_in = '1; timer_irq_i = '1; debug_req_irq = '1;
    clr_valid_i = 1'b0; clr_src_i = 2'd0; clr_core_i = 2'd0;
    #22;
    chk_outs("reset", 6'd0, 3'd0, 3'd0, 1'b0);
    chk("reset.ready", 32'(clr_ready_o), 32'd0);
    chk("reset.dbg", 32'(debug_req_o), 32'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    repeat (8) tick();
    chk_outs("held_high", 6'd0, 3'd0, 3'd0, 1'b0);
    chk("held_high.dbg", 32'(debug_req_o), 32'd0);
    chk("held_high.ready", 32'(clr_ready_o), 32'd1);
    irqs_in = '0; ipi_in = '0; timer_irq_i = '0; debug_req_irq = '0;
    repeat (5) tick();
    chk_outs("drop_inputs", 6'd0, 3'd0, 3'd0, 1'b0);

    // Latency on irqs_in[3]: one-cycle pulse, high after the fourth edge.
    irqs_in[3] = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      if (t == 1) irqs_in[3] = 1'b0;
      chk($sformatf("latency.t%0d", t), 32'(irq_o[3]), (t == 4) ? 32'd1 : 32'd0);
    end
    repeat (5) tick();
    chk("latency.hold", 32'(irq_o), 32'h8);
    do_clear("clr_s1c1", 2'd1, 2'd1, 1'b0);
    chk("clr_s1c1.irq", 32'(irq_o), 32'h0);

    for (int v = 0; v < 5; v++) begin
      irqs_in = vecs[v].irqs; ipi_in = vecs[v].ipi; timer_irq_i = vecs[v].tmr;
      tick();
      irqs_in = '0; ipi_in = '0; timer_irq_i = '0;
      repeat (3) tick();
      chk_outs($sformatf("vec%0d", v), vecs[v].e_irq, vecs[v].e_ipi, vecs[v].e_tmr, 1'b0);
      chk($sformatf("vec%0d.dbg", v), 32'(debug_req_o), 32'd0);
      repeat (2) tick();
    end

    do_clear("clr_s0c2", 2'd0, 2'd2, 1'b0);
    chk_outs("clr_s0c2.st", 6'b100111, 3'b011, 3'b101, 1'b0);
    do_clear("clr_s2c1", 2'd2, 2'd1, 1'b0);
    chk_outs("clr_s2c1.st", 6'b100111, 3'b001, 3'b101, 1'b0);
    do_clear("clr_s3c2", 2'd3, 2'd2, 1'b0);
    chk_outs("clr_s3c2.st", 6'b100111, 3'b001, 3'b001, 1'b0);
    do_clear("clr_err", 2'd0, 2'd3, 1'b1);
    chk_outs("clr_err.st", 6'b100111, 3'b001, 3'b001, 1'b0);

    // Reset while in CLEAR drops the request.
    clr_src_i = 2'd0; clr_core_i = 2'd0; clr_valid_i = 1'b1;
    tick();
    chk("midclr.done_pre", 32'(clr_done_o), 32'd1);
    aresetn = 1'b0;
    #1;
    chk("midclr.done_rst", 32'(clr_done_o), 32'd0);
    chk_outs("midclr", 6'd0, 3'd0, 3'd0, 1'b0);
    clr_valid_i = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();
    chk("midclr.done_after", 32'(clr_done_o), 32'd0);
    chk("midclr.ready_after", 32'(clr_ready_o), 32'd1);
    repeat (4) tick();

    // Lost edge on ipi_in[0].
    ipi_in[0] = 1'b1; tick(); ipi_in[0] = 1'b0;
    repeat (9) tick();
    chk_outs("lost.first", 6'd0, 3'b001, 3'd0, 1'b0);
    ipi_in[0] = 1'b1; tick(); ipi_in[0] = 1'b0;
    repeat (5) tick();
    chk_outs("lost.second", 6'd0, 3'b001, 3'd0, 1'b1);
    do_reset();
    chk_outs("lost.reset", 6'd0, 3'd0, 3'd0, 1'b0);

    // Set/clear race on timer_irq_i[0].
    timer_irq_i[0] = 1'b1; tick(); timer_irq_i[0] = 1'b0;
    repeat (5) tick();
    chk_outs("race.pre", 6'd0, 3'd0, 3'b001, 1'b0);
    timer_irq_i[0] = 1'b1;
    tick();
    timer_irq_i[0] = 1'b0;
    tick();
    clr_src_i = 2'd3; clr_core_i = 2'd0; clr_valid_i = 1'b1;
    tick();
    chk("race.done", 32'(clr_done_o), 32'd1);
    clr_valid_i = 1'b0;
    tick();
    chk_outs("race.post", 6'd0, 3'd0, 3'b001, 1'b0);
    repeat (3) tick();
    do_clear("race.clr", 2'd3, 2'd0, 1'b0);
    chk_outs("race.cleared", 6'd0, 3'd0, 3'd0, 1'b0);

    // Debug stretch: single edge, then a second edge ten cycles later.
    for (int sc = 0; sc < 2; sc++) begin
      cnt = 0; first = -1; last = -1;
      debug_req_irq[0] = 1'b1;
      for (int t = 1; t <= 40; t++) begin
        tick();
        if (t == 1) debug_req_irq[0] = 1'b0;
        if (sc == 1 && t == 10) debug_req_irq[0] = 1'b1;
        if (sc == 1 && t == 11) debug_req_irq[0] = 1'b0;
        if (debug_req_o[0]) begin
          cnt++;
          if (first < 0) first = t;
          last = t;
        end
      end
      chk($sformatf("dbg%0d.count", sc), 32'(cnt), (sc == 0) ? 32'd16 : 32'd26);
      chk($sformatf("dbg%0d.first", sc), 32'(first), 32'd4);
      chk($sformatf("dbg%0d.last", sc), 32'(last), (sc == 0) ? 32'd19 : 32'd29);
      chk($sformatf("dbg%0d.lost", sc), 32'(lost_o), 32'd0);
      chk($sformatf("dbg%0d.others", sc), 32'(debug_req_o), 32'd0);
    end

    // Back-pressure: valid held high gives one acceptance every two cycles.
    clr_src_i = 2'd1; clr_core_i = 2'd0; clr_valid_i = 1'b1;
    done_seq = '0;
    for (int t = 0; t < 8; t++) begin
      tick();
      done_seq[t] = clr_done_o;
    end
    clr_valid_i = 1'b0;
    chk("backpressure.seq", 32'(done_seq), 32'h55);
    tick();
    chk("backpressure.idle", 32'(clr_ready_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
